apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator driving the peripheral bus (GPIO and siblings) from a simple command/response port used by the bench's register-access layer and the CPU-side shim.
- Converts one accepted command into exactly one APB SETUP/ACCESS transfer.
- Honours wait states, returns read data and error status, and aborts hung transfers after a programmable timeout.
- Its bus output must satisfy the team's APB protocol checks: PSEL stable SETUP→ACCESS, PENABLE only with PSEL, address/data/direction stable while PREADY, PENABLE low the cycle after PREADY.

Parameters:
ADDR_W, 32, PADDR/cmd_addr width
DATA_W, 32, PWDATA/PRDATA/cmd_wdata/rsp_rdata width
TIMEOUT, 16, max ACCESS cycles without PREADY before abort; 0 = never abort

Ports:
PCLK  input  1  bus clock, all logic on rising edge
PRESETn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  bridge can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  target address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_W  read data (0 for writes/timeouts)
rsp_err  output  1  PSLVERR sampled at completion, or 1 on timeout
rsp_timeout  output  1  completion was a timeout abort
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_W  APB address
PWDATA  output  DATA_W  APB write data
PREADY  input  1  slave ready
PRDATA  input  DATA_W  slave read data
PSLVERR  input  1  slave error

Behaviour:
- FSM states: IDLE, SETUP, ACCESS. All outputs registered except cmd_ready = (state==IDLE).
- Reset (async, any state): state IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout = 0; PADDR, PWDATA, rsp_rdata = 0; timeout counter = 0. PSEL/PENABLE drop immediately when reset asserts mid-transfer; no response is produced for the aborted command.
- IDLE: on cmd_valid&&cmd_ready, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA; next state SETUP (PSEL=1, PENABLE=0).
- SETUP: exactly one cycle; next state ACCESS (PENABLE=1); counter cleared.
- ACCESS: hold PSEL=1, PENABLE=1, PADDR/PWDATA/PWRITE unchanged.
  - If PREADY=1: next cycle IDLE, PSEL=PENABLE=0, rsp_valid=1, rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout = 0.
  - If PREADY=0: counter increments. When TIMEOUT!=0 and this is the TIMEOUT-th consecutive ACCESS cycle without PREADY: abort. Next cycle IDLE, PSEL=PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY on the TIMEOUT-th cycle means normal completion, not a timeout.
- PREADY, PRDATA and PSLVERR are ignored outside ACCESS.
- PADDR, PWDATA and PWRITE hold their last values in IDLE and change only on command acceptance.
- rsp_valid is high for exactly one cycle, with no backpressure. rsp_rdata, rsp_err and rsp_timeout hold until the next completion.
- Latency, zero wait states: accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
- Back-to-back: a command may be accepted in the same cycle rsp_valid is high. PSEL is therefore low for at least one cycle between transfers.
- cmd_valid is ignored in SETUP and ACCESS; the requester holds the command until cmd_ready.

Test Plan:
- Write addr 0x0000_0008, data 0xA5A5_0001, PREADY tied 1 → PSEL high cycles 1–2, PENABLE cycle 2 only, PWRITE=1; rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
- Read addr 0x0000_0004, PREADY low 3 ACCESS cycles then high, PRDATA=0x1234_5678 → PENABLE high 4 cycles with PADDR stable; rsp_rdata=0x1234_5678 one cycle after PREADY.
- Read with PSLVERR=1 at PREADY → rsp_err=1, rsp_timeout=0.
- TIMEOUT=16, PREADY never asserted → PSEL/PENABLE drop after 16 ACCESS cycles; rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0; cmd_ready=1 again.
- cmd_valid held high for 4 writes, zero wait → one transfer per 3 cycles, PENABLE low the cycle after each PREADY, PADDR updating only on acceptance.
- PRESETn pulsed low during ACCESS with PREADY=0 → PSEL=PENABLE=0 immediately, no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one accepted command into one SETUP/ACCESS transfer,
// honouring wait states, slave errors and an optional ACCESS-phase timeout.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_hit;

  // cnt_q counts completed stalled ACCESS cycles, so the current one is the
  // TIMEOUT-th when it already holds TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: fixed cycle-by-cycle steps with
// hand-computed expectations, checked by immediate assertions.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int compared   = 0;
  int mismatched = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One command's address-phase strobes plus the response pulse.
  task automatic checkBus(input string tag, input logic sel, input logic en,
                          input logic rv);
    checkOutput({tag, ".PSEL"}, {31'd0, PSEL}, {31'd0, sel});
    checkOutput({tag, ".PENABLE"}, {31'd0, PENABLE}, {31'd0, en});
    checkOutput({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, rv});
  endtask

  initial begin
    PRESETn = 1'b0;
    PREADY  = 1'b0;
    PRDATA  = 32'h0;
    PSLVERR = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    $display("[TB] reset state");
    checkBus("rst", 1'b0, 1'b0, 1'b0);
    checkOutput("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst.PADDR", PADDR, 32'h0);
    checkOutput("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    PRESETn = 1'b1;
    tick();

    $display("[TB] zero-wait write");
    PREADY = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_0001);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkBus("wr.setup", 1'b1, 1'b0, 1'b0);
    checkOutput("wr.cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("wr.PWRITE", {31'd0, PWRITE}, 32'd1);
    checkOutput("wr.PADDR", PADDR, 32'h0000_0008);
    checkOutput("wr.PWDATA", PWDATA, 32'hA5A5_0001);
    tick();
    checkBus("wr.access", 1'b1, 1'b1, 1'b0);
    tick();
    checkBus("wr.done", 1'b0, 1'b0, 1'b1);
    checkOutput("wr.rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("wr.rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("wr.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    checkBus("wr.after", 1'b0, 1'b0, 1'b0);
    checkOutput("wr.PADDR_hold", PADDR, 32'h0000_0008);

    $display("[TB] read with three wait states");
    PREADY = 1'b0;
    PRDATA = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkBus("rd.setup", 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkBus("rd.wait", 1'b1, 1'b1, 1'b0);
      checkOutput("rd.wait.PADDR", PADDR, 32'h0000_0004);
      tick();
    end
    PREADY = 1'b1;
    PRDATA = 32'h1234_5678;
    checkBus("rd.ready", 1'b1, 1'b1, 1'b0);
    checkOutput("rd.PWRITE", {31'd0, PWRITE}, 32'd0);
    tick();
    checkBus("rd.done", 1'b0, 1'b0, 1'b1);
    checkOutput("rd.rsp_rdata", rsp_rdata, 32'h1234_5678);
    checkOutput("rd.rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();

    $display("[TB] read with slave error");
    PSLVERR = 1'b1;
    PRDATA  = 32'h55AA_55AA;
    applyStimulus(1'b1, 1'b0, 32'h0000_000C, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkBus("err.done", 1'b0, 1'b0, 1'b1);
    checkOutput("err.rsp_err", {31'd0, rsp_err}, 32'd1);
    checkOutput("err.rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    checkOutput("err.rsp_rdata", rsp_rdata, 32'h55AA_55AA);
    PSLVERR = 1'b0;
    tick();
    checkOutput("err.rsp_err_hold", {31'd0, rsp_err}, 32'd1);

    $display("[TB] timeout after 16 stalled ACCESS cycles");
    PREADY = 1'b0;
    PRDATA = 32'hCAFE_F00D;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 1; i <= 16; i++) begin
      checkBus("to.wait", 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkBus("to.abort", 1'b0, 1'b0, 1'b1);
    checkOutput("to.rsp_err", {31'd0, rsp_err}, 32'd1);
    checkOutput("to.rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    checkOutput("to.rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("to.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();

    $display("[TB] PREADY on the 16th ACCESS cycle completes normally");
    applyStimulus(1'b1, 1'b0, 32'h0000_0014, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 1; i <= 15; i++) tick();
    PREADY = 1'b1;
    PRDATA = 32'h0F0F_1616;
    checkBus("edge.last", 1'b1, 1'b1, 1'b0);
    tick();
    checkBus("edge.done", 1'b0, 1'b0, 1'b1);
    checkOutput("edge.rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    checkOutput("edge.rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("edge.rsp_rdata", rsp_rdata, 32'h0F0F_1616);
    tick();

    $display("[TB] four back-to-back writes");
    PREADY = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h1111_0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkBus("b2b.setup", 1'b1, 1'b0, 1'b0);
      checkOutput("b2b.setup.PADDR", PADDR, 32'h0000_0020 + 32'(4 * k));
      checkOutput("b2b.setup.PWDATA", PWDATA, 32'h1111_0000 + 32'(k));
      if (k < 3)
        applyStimulus(1'b1, 1'b1, 32'h0000_0024 + 32'(4 * k), 32'h1111_0001 + 32'(k));
      else
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checkBus("b2b.access", 1'b1, 1'b1, 1'b0);
      checkOutput("b2b.access.PADDR", PADDR, 32'h0000_0020 + 32'(4 * k));
      tick();
      checkBus("b2b.done", 1'b0, 1'b0, 1'b1);
      checkOutput("b2b.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end
    tick();
    checkBus("b2b.idle", 1'b0, 1'b0, 1'b0);
    checkOutput("b2b.PADDR_hold", PADDR, 32'h0000_002C);

    $display("[TB] reset asserted during ACCESS");
    PREADY = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h0000_0030, 32'h7777_7777);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkBus("rst2.access", 1'b1, 1'b1, 1'b0);
    PRESETn = 1'b0;
    #1;
    checkBus("rst2.async", 1'b0, 1'b0, 1'b0);
    checkOutput("rst2.PADDR", PADDR, 32'h0);
    checkOutput("rst2.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    checkBus("rst2.held", 1'b0, 1'b0, 1'b0);
    PRESETn = 1'b1;
    tick();
    checkOutput("rst2.no_rsp", {31'd0, rsp_valid}, 32'd0);
    PREADY = 1'b1;
    PRDATA = 32'h0BAD_F00D;
    applyStimulus(1'b1, 1'b0, 32'h0000_0034, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rst2.next.PADDR", PADDR, 32'h0000_0034);
    tick();
    tick();
    checkBus("rst2.next.done", 1'b0, 1'b0, 1'b1);
    checkOutput("rst2.next.rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    checkOutput("rst2.next.rsp_err", {31'd0, rsp_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
